// File: rtl/m_dmem_responder_if.sv
// Load/store request and response channels between
// the processor data port and the memory responder.
interface m_dmem_responder_if;
    logic        w_req_valid;
    logic        w_req_ready;
    logic        w_req_we;
    logic [2:0]  w_req_funct3;
    logic [31:0] w_req_addr;
    logic [31:0] w_req_wdata;
    logic        w_rsp_valid;
    logic        w_rsp_ready;
    logic [31:0] w_rsp_rdata;
    logic        w_rsp_err;

    modport master (
        output w_req_valid, w_req_we, w_req_funct3,
        output w_req_addr, w_req_wdata, w_rsp_ready,
        input  w_req_ready, w_rsp_valid,
        input  w_rsp_rdata, w_rsp_err
    );

    modport slave (
        input  w_req_valid, w_req_we, w_req_funct3,
        input  w_req_addr, w_req_wdata, w_rsp_ready,
        output w_req_ready, w_rsp_valid,
        output w_rsp_rdata, w_rsp_err
    );
endinterface

// File: rtl/m_dmem_responder.sv
// Data-memory responder: one outstanding RV32I load/store,
// fixed access latency, registered response channel.
module m_dmem_responder #(
    parameter int ADDR_W  = 5,
    parameter int LATENCY = 2
) (
    input logic              w_clk,
    input logic              w_rst_n,
    m_dmem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int         DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    logic [31:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              accept, enter_resp;
    logic [ADDR_W-1:0] idx_q;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic              we_q, err_q;
    logic              rsp_valid_q, rsp_err_q;
    logic [31:0]       rsp_rdata_q;

    logic [ADDR_W-1:0] idx_in;
    logic [1:0]        off_in;
    logic [2:0]        f3_in;
    logic              illegal, misaligned, req_err;
    logic [3:0]        be;
    logic [31:0]       wdat;
    logic              unused_addr;

    assign idx_in      = bus.w_req_addr[ADDR_W+1:2];
    assign off_in      = bus.w_req_addr[1:0];
    assign f3_in       = bus.w_req_funct3;
    assign unused_addr = ^bus.w_req_addr[31:ADDR_W+2];

    // Request legality and store lane selection
    always_comb begin
        illegal = 1'b1;
        unique case (f3_in)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = bus.w_req_we;
            default:                illegal = 1'b1;
        endcase
        misaligned = (f3_in[1:0] == 2'b01 && off_in[0])
                   || (f3_in[1:0] == 2'b10 && off_in != 2'b00);
        req_err = illegal | misaligned;
        be   = 4'b1111;
        wdat = bus.w_req_wdata;
        unique case (f3_in[1:0])
            2'b00: begin
                be   = 4'b0001 << off_in;
                wdat = {4{bus.w_req_wdata[7:0]}};
            end
            2'b01: begin
                be   = 4'b0011 << off_in;
                wdat = {2{bus.w_req_wdata[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wdat = bus.w_req_wdata;
            end
        endcase
    end

    logic [31:0] word;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ld, ld_final;

    always_comb begin
        word   = mem[idx_q];
        byte_v = word[{off_q, 3'b000} +: 8];
        half_v = word[{off_q[1], 4'b0000} +: 16];
        unique case (f3_q)
            3'b000:  ld = {{24{byte_v[7]}}, byte_v};
            3'b100:  ld = {24'b0, byte_v};
            3'b001:  ld = {{16{half_v[15]}}, half_v};
            3'b101:  ld = {16'b0, half_v};
            default: ld = word;
        endcase
        ld_final = (we_q | err_q) ? 32'b0 : ld;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.w_req_valid) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                    cnt_d   = LAT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (bus.w_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            off_q       <= 2'b0;
            f3_q        <= 3'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= (state_d == RESP);
            if (accept) begin
                idx_q <= idx_in;
                off_q <= off_in;
                f3_q  <= f3_in;
                we_q  <= bus.w_req_we;
                err_q <= req_err;
            end
            if (enter_resp) begin
                rsp_rdata_q <= ld_final;
                rsp_err_q   <= err_q;
            end
        end
    end

    // Storage is not reset; stores commit at acceptance
    always_ff @(posedge w_clk) begin
        if (accept && bus.w_req_we && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx_in][8*i +: 8] <= wdat[8*i +: 8];
            end
        end
    end

    assign bus.w_req_ready = (state_q == IDLE);
    assign bus.w_rsp_valid = rsp_valid_q;
    assign bus.w_rsp_rdata = rsp_rdata_q;
    assign bus.w_rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_m_dmem_responder.sv
// Bench for m_dmem_responder: directed steps plus random
// loads/stores against a byte-array memory model.
module tb_m_dmem_responder;
    logic clk;
    logic rst_n;
    int   total  = 0;
    int   passed = 0;

    m_dmem_responder_if bus0 ();
    m_dmem_responder_if bus1 ();

    m_dmem_responder #(.ADDR_W(5), .LATENCY(2)) u_dut (
        .w_clk(clk), .w_rst_n(rst_n), .bus(bus0.slave)
    );
    m_dmem_responder #(.ADDR_W(5), .LATENCY(1)) u_dut1 (
        .w_clk(clk), .w_rst_n(rst_n), .bus(bus1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] mb [128];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mword(input int w);
        return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
    endfunction

    task automatic push_mem();
        for (int w = 0; w < 32; w++) u_dut.mem[w] = mword(w);
    endtask

    function automatic void ref_model(
        input logic we, input logic [2:0] f3,
        input logic [31:0] addr, input logic [31:0] wdata,
        output logic [31:0] rd, output logic err);
        int sz;
        logic [31:0] a;
        logic [31:0] v;
        sz  = 1 << f3[1:0];
        err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)
            || (we && f3[2]) || ((addr % sz) != 0);
        rd = 32'b0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < sz; i++) begin
                a = addr + i;
                mb[a[6:0]] = wdata[8*i +: 8];
            end
            return;
        end
        v = 32'b0;
        for (int i = 0; i < sz; i++) begin
            a = addr + i;
            v = v | ({24'b0, mb[a[6:0]]} << (8 * i));
        end
        if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
        rd = v;
    endfunction

    task automatic txn0(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int stall, output logic [31:0] rd,
                        output logic err);
        int lat;
        @(negedge clk);
        chk("idle_ready", bus0.w_req_ready, 1);
        bus0.w_req_valid  = 1'b1;
        bus0.w_req_we     = we;
        bus0.w_req_funct3 = f3;
        bus0.w_req_addr   = addr;
        bus0.w_req_wdata  = wdata;
        bus0.w_rsp_ready  = 1'b0;
        @(posedge clk);
        #1;
        bus0.w_req_valid = 1'b0;
        lat = 0;
        while (!bus0.w_rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 2);
        chk("busy_ready", bus0.w_req_ready, 0);
        rd  = bus0.w_rsp_rdata;
        err = bus0.w_rsp_err;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", bus0.w_rsp_valid, 1);
            chk("hold_rdata", bus0.w_rsp_rdata, rd);
            chk("hold_ready", bus0.w_req_ready, 0);
        end
        bus0.w_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus0.w_rsp_ready = 1'b0;
        chk("post_hs_valid", bus0.w_rsp_valid, 0);
        chk("post_hs_ready", bus0.w_req_ready, 1);
    endtask

    task automatic run(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int stall, output logic [31:0] rd,
                       output logic err);
        logic [31:0] erd;
        logic        eerr;
        ref_model(we, f3, addr, wdata, erd, eerr);
        txn0(we, f3, addr, wdata, stall, rd, err);
        chk("model_rdata", rd, erd);
        chk("model_err", err, eerr);
    endtask

    task automatic txn1(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd,
                        output int lat);
        @(negedge clk);
        bus1.w_req_valid  = 1'b1;
        bus1.w_req_we     = we;
        bus1.w_req_funct3 = 3'b010;
        bus1.w_req_addr   = addr;
        bus1.w_req_wdata  = wdata;
        bus1.w_rsp_ready  = 1'b1;
        @(posedge clk);
        #1;
        bus1.w_req_valid = 1'b0;
        lat = 0;
        while (!bus1.w_rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = bus1.w_rsp_rdata;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    logic        err;
    int          lat;
    logic        seen;
    logic [2:0]  f3;
    logic        we;
    logic [31:0] addr;

    initial begin
        rst_n = 1'b0;
        bus0.w_req_valid = 1'b0; bus0.w_req_we = 1'b0;
        bus0.w_req_funct3 = 3'b0; bus0.w_req_addr = 32'b0;
        bus0.w_req_wdata = 32'b0; bus0.w_rsp_ready = 1'b0;
        bus1.w_req_valid = 1'b0; bus1.w_req_we = 1'b0;
        bus1.w_req_funct3 = 3'b0; bus1.w_req_addr = 32'b0;
        bus1.w_req_wdata = 32'b0; bus1.w_rsp_ready = 1'b0;
        for (int i = 0; i < 128; i++) mb[i] = 8'($urandom);
        #12;
        chk("rst_ready", bus0.w_req_ready, 1);
        chk("rst_valid", bus0.w_rsp_valid, 0);
        chk("rst_rdata", bus0.w_rsp_rdata, 0);
        chk("rst_err", bus0.w_rsp_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        push_mem();

        run(1, 3'b010, 8, 7, 0, rd, err);
        chk("sw_err", err, 0);
        chk("sw_rdata", rd, 0);
        chk("sw_mem2", u_dut.mem[2], 7);
        run(0, 3'b010, 8, 0, 0, rd, err);
        chk("lw_8", rd, 7);

        {mb[15], mb[14], mb[13], mb[12]} = 32'h1122_3344;
        push_mem();
        run(1, 3'b000, 13, 32'h0000_0080, 0, rd, err);
        chk("sb_mem3", u_dut.mem[3], 32'h1122_8044);
        run(0, 3'b000, 13, 0, 0, rd, err);
        chk("lb_13", rd, 32'hFFFF_FF80);
        run(0, 3'b100, 13, 0, 0, rd, err);
        chk("lbu_13", rd, 32'h0000_0080);
        run(1, 3'b001, 14, 32'h0000_8001, 0, rd, err);
        run(0, 3'b001, 14, 0, 0, rd, err);
        chk("lh_14", rd, 32'hFFFF_8001);
        run(0, 3'b101, 14, 0, 0, rd, err);
        chk("lhu_14", rd, 32'h0000_8001);

        {mb[7], mb[6], mb[5], mb[4]} = 32'd5;
        push_mem();
        run(1, 3'b010, 6, 9, 0, rd, err);
        chk("sw6_err", err, 1);
        chk("sw6_rdata", rd, 0);
        chk("sw6_mem1", u_dut.mem[1], 5);
        run(0, 3'b001, 3, 0, 0, rd, err);
        chk("lh3_err", err, 1);
        run(0, 3'b011, 8, 0, 0, rd, err);
        chk("f3_011_err", err, 1);
        run(1, 3'b100, 8, 32'hAA, 0, rd, err);
        chk("sbu_err", err, 1);
        chk("sbu_mem2", u_dut.mem[2], 7);

        run(0, 3'b010, 8, 0, 3, rd, err);
        chk("bp_rdata", rd, 7);
        run(0, 3'b010, 4 * 32 + 8, 0, 0, rd, err);
        chk("wrap_lw", rd, 7);

        for (int n = 0; n < 60; n++) begin
            we   = 1'($urandom);
            f3   = 3'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0)
                addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
            run(we, f3, addr, $urandom, $urandom_range(0, 2), rd, err);
        end
        for (int w = 0; w < 32; w++)
            chk("mem_word", u_dut.mem[w], mword(w));

        @(negedge clk);
        bus0.w_req_valid = 1'b1; bus0.w_req_we = 1'b0;
        bus0.w_req_funct3 = 3'b010; bus0.w_req_addr = 8;
        @(posedge clk);
        #1;
        bus0.w_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("pre_rst_valid", bus0.w_rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_ready", bus0.w_req_ready, 1);
        chk("async_valid", bus0.w_rsp_valid, 0);
        chk("async_rdata", bus0.w_rsp_rdata, 0);
        chk("async_err", bus0.w_rsp_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        bus0.w_req_valid = 1'b1; bus0.w_req_we = 1'b1;
        bus0.w_req_funct3 = 3'b010; bus0.w_req_addr = 0;
        bus0.w_req_wdata = 3; bus0.w_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus0.w_req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus0.w_rsp_valid) seen = 1'b1;
        end
        chk("wait_rst_norsp", seen, 0);
        chk("wait_rst_ready", bus0.w_req_ready, 1);
        chk("wait_rst_mem0", u_dut.mem[0], 3);
        bus0.w_rsp_ready = 1'b0;

        txn1(1, 16, 32'h55, rd, lat);
        chk("l1_sw_lat", 32'(lat), 1);
        chk("l1_sw_rdata", rd, 0);
        txn1(0, 16, 0, rd, lat);
        chk("l1_lw_lat", 32'(lat), 1);
        chk("l1_lw_rdata", rd, 32'h55);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
